// File: rtl/toy_intr_pkg.sv
// Shared types and constants for the interrupt controller: op codes,
// pending-bit positions and the request FSM states.
package toy_intr_pkg;

    typedef enum logic [3:0] {
        INTR_SW  = 4'd3,
        INTR_TMR = 4'd7,
        INTR_EXT = 4'd11,
        INTR_DBG = 4'd15
    } intr_op_e;

    // Bit positions inside the pending / eligible / winner vectors.
    // sw/timer/ext line up with the csr_mie bits {meie, mtie, msie}.
    localparam int PEND_SW  = 0;
    localparam int PEND_TMR = 1;
    localparam int PEND_EXT = 2;
    localparam int PEND_DBG = 3;
    localparam int NUM_SRC  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_CLR = 2'd2
    } intr_state_e;

endpackage

// File: rtl/toy_intr_ctrl_if.sv
// Request channel between the interrupt controller and the core front end.
// The controller (master) raises vld/op; the front end answers with rdy and,
// once the handler finishes, clr.
interface toy_intr_ctrl_if #(
    parameter int OP_W = 4
) ();
    logic            intr_vld;
    logic [OP_W-1:0] intr_op;
    logic            intr_rdy;
    logic            intr_clr;

    modport master (output intr_vld, output intr_op, input intr_rdy, input intr_clr);
    modport slave  (input intr_vld, input intr_op, output intr_rdy, output intr_clr);
endinterface

// File: rtl/toy_intr_prio_sel.sv
// Fixed-priority selector: debug > ext > sw > timer.
// Returns a one-hot winner vector and its op code.
module toy_intr_prio_sel
    import toy_intr_pkg::*;
(
    input  logic [NUM_SRC-1:0] elig,
    output logic [NUM_SRC-1:0] win,
    output intr_op_e           win_op,
    output logic               any_elig
);

    // Pick the highest-priority eligible source.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if/else chain leaves a value unassigned (which would infer a latch).
        win      = '0;
        win_op   = INTR_SW;
        any_elig = |elig;
        if (elig[PEND_DBG]) begin
            win[PEND_DBG] = 1'b1;
            win_op        = INTR_DBG;
        end else if (elig[PEND_EXT]) begin
            win[PEND_EXT] = 1'b1;
            win_op        = INTR_EXT;
        end else if (elig[PEND_SW]) begin
            win[PEND_SW] = 1'b1;
            win_op       = INTR_SW;
        end else if (elig[PEND_TMR]) begin
            win[PEND_TMR] = 1'b1;
            win_op        = INTR_TMR;
        end
    end

endmodule

// File: rtl/toy_intr_ctrl.sv
// Interrupt controller: latches sync pulses into pending bits, gates them
// with the CSR enables, and issues one request at a time to the front end.
module toy_intr_ctrl
    import toy_intr_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int CLR_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  intr_meip_sync,
    input  logic                  intr_msip_sync,
    input  logic                  intr_mtip_sync,
    input  logic                  intr_debug_sync,
    input  logic                  csr_mstatus_mie,
    input  logic [2:0]            csr_mie,
    input  logic                  debug_mode,
    toy_intr_ctrl_if.master       intr_bus,
    output logic [NUM_SRC-1:0]    intr_pend
);

    // A zero timeout still needs a legal one-bit counter; it just never fires.
    localparam int               CNT_W      = (CLR_TIMEOUT > 0) ? $clog2(CLR_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLR_TIMEOUT);
    localparam bit               TIMEOUT_EN = (CLR_TIMEOUT > 0);

    intr_state_e        state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d, pend_clr;
    logic [NUM_SRC-1:0] win_q, win_d;
    logic [NUM_SRC-1:0] sync_vec, elig, sel_win;
    logic               vld_q, vld_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    intr_op_e           sel_op;
    logic               any_elig, irq_en, keep_req, timeout_hit;

    assign sync_vec = {intr_debug_sync, intr_meip_sync, intr_mtip_sync, intr_msip_sync};

    // Gate pending bits with the enables; debug only respects debug_mode.
    always_comb begin
        irq_en         = csr_mstatus_mie & ~debug_mode;
        elig           = '0;
        elig[PEND_SW]  = pend_q[PEND_SW]  & csr_mie[0] & irq_en;
        elig[PEND_TMR] = pend_q[PEND_TMR] & csr_mie[1] & irq_en;
        elig[PEND_EXT] = pend_q[PEND_EXT] & csr_mie[2] & irq_en;
        elig[PEND_DBG] = pend_q[PEND_DBG] & ~debug_mode;
    end

    toy_intr_prio_sel u_prio_sel (
        .elig     (elig),
        .win      (sel_win),
        .win_op   (sel_op),
        .any_elig (any_elig)
    );

    // A request in flight stays up while its source is still eligible;
    // a debug request is never withdrawn.
    assign keep_req    = win_q[PEND_DBG] | (|(win_q & elig));
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_MAX);

    // Next-state, request outputs and pending-clear for the request FSM.
    always_comb begin
        state_d  = state_q;
        vld_d    = vld_q;
        op_d     = op_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        pend_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = REQ;
                    vld_d   = 1'b1;
                    op_d    = sel_op;
                    win_d   = sel_win;
                end
            end
            REQ: begin
                if (intr_bus.intr_rdy) begin
                    pend_clr = win_q;
                    vld_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = WAIT_CLR;
                end else if (!keep_req) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_CLR: begin
                if (intr_bus.intr_clr || timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // Acceptance clears the winner's bit, but a new pulse in the same cycle wins.
    assign pend_d = (pend_q & ~pend_clr) | sync_vec;

    // State registers; reset drops everything, including pending interrupts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            win_q   <= '0;
            vld_q   <= 1'b0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            pend_q  <= pend_d;
            win_q   <= win_d;
            vld_q   <= vld_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign intr_bus.intr_vld = vld_q;
    assign intr_bus.intr_op  = OP_W'(op_q);
    assign intr_pend         = pend_q;

endmodule

// File: tb/tb_toy_intr_ctrl.sv
// Self-checking bench for toy_intr_ctrl (CLR_TIMEOUT = 8). Expected op codes
// are queued when the pulses are driven and popped when a request appears.
module tb_toy_intr_ctrl;
    import toy_intr_pkg::*;

    localparam int OP_W        = 4;
    localparam int CLR_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       intr_meip_sync = 1'b0;
    logic       intr_msip_sync = 1'b0;
    logic       intr_mtip_sync = 1'b0;
    logic       intr_debug_sync = 1'b0;
    logic       csr_mstatus_mie = 1'b0;
    logic [2:0] csr_mie = 3'b000;
    logic       debug_mode = 1'b0;
    logic [3:0] intr_pend;

    toy_intr_ctrl_if #(.OP_W(OP_W)) bus ();

    toy_intr_ctrl #(.OP_W(OP_W), .CLR_TIMEOUT(CLR_TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .intr_meip_sync  (intr_meip_sync),
        .intr_msip_sync  (intr_msip_sync),
        .intr_mtip_sync  (intr_mtip_sync),
        .intr_debug_sync (intr_debug_sync),
        .csr_mstatus_mie (csr_mstatus_mie),
        .csr_mie         (csr_mie),
        .debug_mode      (debug_mode),
        .intr_bus        (bus),
        .intr_pend       (intr_pend)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              fails  = 0;
    logic [OP_W-1:0] exp_q[$];
    logic [OP_W-1:0] exp_op;
    bit              seen;
    int              n;

    // Advance to just after the next rising edge (drive and sample point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle sync pulse; mask = {debug, ext, timer, sw}.
    task automatic pulse(input logic [3:0] m);
        {intr_debug_sync, intr_meip_sync, intr_mtip_sync, intr_msip_sync} = m;
        tick();
        {intr_debug_sync, intr_meip_sync, intr_mtip_sync, intr_msip_sync} = 4'b0000;
    endtask

    task automatic do_clr();
        bus.intr_clr = 1'b1;
        tick();
        bus.intr_clr = 1'b0;
    endtask

    // Bounded wait for intr_vld; reports whether it came and after how many ticks.
    task automatic wait_vld(input int budget, output bit got, output int cnt);
        cnt = 0;
        got = bus.intr_vld;
        while (!got && cnt < budget) begin
            tick();
            cnt++;
            got = bus.intr_vld;
        end
    endtask

    task automatic pop_exp(output logic [OP_W-1:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", bus.intr_vld); end
        checks++; if (bus.intr_op !== 4'd0) begin fails++; $display("FAIL reset_op: got %0d want 0", bus.intr_op); end
        checks++; if (intr_pend !== 4'b0000) begin fails++; $display("FAIL reset_pend: got %b want 0000", intr_pend); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL reset_idle_vld: got %b want 0", bus.intr_vld); end
    endtask

    task automatic test_single_ext();
        csr_mstatus_mie = 1'b1; csr_mie = 3'b100; bus.intr_rdy = 1'b1;
        tick();
        exp_q.push_back(OP_W'(INTR_EXT));
        pulse(4'b0100);
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL ext_lat_n1_vld: got %b want 0", bus.intr_vld); end
        checks++; if (intr_pend !== 4'b0100) begin fails++; $display("FAIL ext_pend_set: got %b want 0100", intr_pend); end
        tick();
        pop_exp(exp_op);
        checks++; if (bus.intr_vld !== 1'b1) begin fails++; $display("FAIL ext_lat_n2_vld: got %b want 1", bus.intr_vld); end
        checks++; if (bus.intr_op !== exp_op) begin fails++; $display("FAIL ext_op: got %0d want %0d", bus.intr_op, exp_op); end
        tick();
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL ext_accept_vld: got %b want 0", bus.intr_vld); end
        checks++; if (intr_pend !== 4'b0000) begin fails++; $display("FAIL ext_pend_clr: got %b want 0000", intr_pend); end
        exp_q.push_back(OP_W'(INTR_EXT));
        pulse(4'b0100);
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL ext_blocked_%0d: got %b want 0", k, bus.intr_vld); end
            tick();
        end
        do_clr();
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL b2b_m1_vld: got %b want 0", bus.intr_vld); end
        tick();
        pop_exp(exp_op);
        checks++; if (bus.intr_vld !== 1'b1) begin fails++; $display("FAIL b2b_m2_vld: got %b want 1", bus.intr_vld); end
        checks++; if (bus.intr_op !== exp_op) begin fails++; $display("FAIL b2b_op: got %0d want %0d", bus.intr_op, exp_op); end
        tick();
        do_clr();
        repeat (2) tick();
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL ext_idle_vld: got %b want 0", bus.intr_vld); end
    endtask

    task automatic test_priority();
        csr_mstatus_mie = 1'b1; csr_mie = 3'b111; bus.intr_rdy = 1'b1;
        exp_q.push_back(OP_W'(INTR_EXT));
        exp_q.push_back(OP_W'(INTR_SW));
        exp_q.push_back(OP_W'(INTR_TMR));
        pulse(4'b0111);
        for (int i = 0; i < 3; i++) begin
            wait_vld(6, seen, n);
            checks++; if (!seen) begin fails++; $display("FAIL prio_vld_%0d: no vld within 6 cycles", i); end
            checks++; if (n !== 1) begin fails++; $display("FAIL prio_latency_%0d: got %0d cycles want 1", i, n); end
            pop_exp(exp_op);
            checks++; if (bus.intr_op !== exp_op) begin fails++; $display("FAIL prio_op_%0d: got %0d want %0d", i, bus.intr_op, exp_op); end
            tick();
            do_clr();
        end
        checks++; if (intr_pend !== 4'b0000) begin fails++; $display("FAIL prio_pend_end: got %b want 0000", intr_pend); end
    endtask

    task automatic test_debug();
        csr_mstatus_mie = 1'b0; csr_mie = 3'b000; bus.intr_rdy = 1'b1;
        exp_q.push_back(OP_W'(INTR_DBG));
        pulse(4'b1000);
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen) begin fails++; $display("FAIL dbg_vld: no vld within 4 cycles"); end
        checks++; if (bus.intr_op !== exp_op) begin fails++; $display("FAIL dbg_op: got %0d want %0d", bus.intr_op, exp_op); end
        tick();
        do_clr();
        debug_mode = 1'b1;
        pulse(4'b1000);
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL dbg_mode_masked_%0d: got %b want 0", k, bus.intr_vld); end
            tick();
        end
        checks++; if (intr_pend !== 4'b1000) begin fails++; $display("FAIL dbg_mode_pend: got %b want 1000", intr_pend); end
        debug_mode = 1'b0;
        exp_q.push_back(OP_W'(INTR_DBG));
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen) begin fails++; $display("FAIL dbg_release_vld: no vld within 4 cycles"); end
        checks++; if (bus.intr_op !== exp_op) begin fails++; $display("FAIL dbg_release_op: got %0d want %0d", bus.intr_op, exp_op); end
        tick();
        do_clr();
    endtask

    task automatic test_backpressure();
        csr_mstatus_mie = 1'b1; csr_mie = 3'b100; bus.intr_rdy = 1'b0;
        exp_q.push_back(OP_W'(INTR_EXT));
        pulse(4'b0100);
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen) begin fails++; $display("FAIL bp_vld: no vld within 4 cycles"); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.intr_vld !== 1'b1 || bus.intr_op !== exp_op) begin
                fails++; $display("FAIL bp_hold_%0d: got vld=%b op=%0d want vld=1 op=%0d", k, bus.intr_vld, bus.intr_op, exp_op);
            end
            if (k == 2) begin
                exp_q.push_back(OP_W'(INTR_DBG));
                pulse(4'b1000);
            end else begin
                tick();
            end
        end
        bus.intr_rdy = 1'b1;
        tick();
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL bp_accept_vld: got %b want 0", bus.intr_vld); end
        checks++; if (intr_pend !== 4'b1000) begin fails++; $display("FAIL bp_pend: got %b want 1000", intr_pend); end
        do_clr();
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen) begin fails++; $display("FAIL bp_dbg_vld: no vld within 4 cycles"); end
        checks++; if (bus.intr_op !== exp_op) begin fails++; $display("FAIL bp_dbg_op: got %0d want %0d", bus.intr_op, exp_op); end
        tick();
        do_clr();
    endtask

    task automatic test_withdrawal();
        csr_mstatus_mie = 1'b1; csr_mie = 3'b001; bus.intr_rdy = 1'b0;
        exp_q.push_back(OP_W'(INTR_SW));
        pulse(4'b0001);
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen || bus.intr_op !== exp_op) begin fails++; $display("FAIL wd_first: got vld=%b op=%0d want vld=1 op=%0d", seen, bus.intr_op, exp_op); end
        tick();
        csr_mie = 3'b000;
        tick();
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL wd_drop_vld: got %b want 0", bus.intr_vld); end
        checks++; if (intr_pend[PEND_SW] !== 1'b1) begin fails++; $display("FAIL wd_pend_kept: got %b want 1", intr_pend[PEND_SW]); end
        tick();
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL wd_stay_idle: got %b want 0", bus.intr_vld); end
        csr_mie = 3'b001;
        exp_q.push_back(OP_W'(INTR_SW));
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen || n !== 1) begin fails++; $display("FAIL wd_reissue_vld: got seen=%b after %0d cycles want 1 after 1", seen, n); end
        checks++; if (bus.intr_op !== exp_op) begin fails++; $display("FAIL wd_reissue_op: got %0d want %0d", bus.intr_op, exp_op); end
        bus.intr_rdy = 1'b1;
        tick();
        checks++; if (intr_pend !== 4'b0000) begin fails++; $display("FAIL wd_pend_clr: got %b want 0000", intr_pend); end
        do_clr();
    endtask

    task automatic test_set_wins();
        csr_mstatus_mie = 1'b1; csr_mie = 3'b001; bus.intr_rdy = 1'b0;
        exp_q.push_back(OP_W'(INTR_SW));
        pulse(4'b0001);
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen || bus.intr_op !== exp_op) begin fails++; $display("FAIL sw_first: got vld=%b op=%0d want vld=1 op=%0d", seen, bus.intr_op, exp_op); end
        bus.intr_rdy = 1'b1;
        exp_q.push_back(OP_W'(INTR_SW));
        pulse(4'b0001);
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL sw_accept_vld: got %b want 0", bus.intr_vld); end
        checks++; if (intr_pend !== 4'b0001) begin fails++; $display("FAIL set_wins_pend: got %b want 0001", intr_pend); end
        do_clr();
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen || bus.intr_op !== exp_op) begin fails++; $display("FAIL set_wins_reissue: got vld=%b op=%0d want vld=1 op=%0d", seen, bus.intr_op, exp_op); end
        tick();
        do_clr();
    endtask

    task automatic test_reset_mid();
        csr_mstatus_mie = 1'b1; csr_mie = 3'b100; bus.intr_rdy = 1'b1;
        exp_q.push_back(OP_W'(INTR_EXT));
        pulse(4'b0100);
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen || bus.intr_op !== exp_op) begin fails++; $display("FAIL rm_issue: got vld=%b op=%0d want vld=1 op=%0d", seen, bus.intr_op, exp_op); end
        tick();
        pulse(4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.intr_vld !== 1'b0) begin fails++; $display("FAIL rm_vld: got %b want 0", bus.intr_vld); end
        checks++; if (bus.intr_op !== 4'd0) begin fails++; $display("FAIL rm_op: got %0d want 0", bus.intr_op); end
        checks++; if (intr_pend !== 4'b0000) begin fails++; $display("FAIL rm_pend: got %b want 0000", intr_pend); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if (bus.intr_vld !== 1'b0 || intr_pend !== 4'b0000) begin fails++; $display("FAIL rm_after: got vld=%b pend=%b want 0 0000", bus.intr_vld, intr_pend); end
    endtask

    task automatic test_timeout();
        csr_mstatus_mie = 1'b1; csr_mie = 3'b111; bus.intr_rdy = 1'b1;
        exp_q.push_back(OP_W'(INTR_EXT));
        exp_q.push_back(OP_W'(INTR_SW));
        pulse(4'b0101);
        wait_vld(4, seen, n);
        pop_exp(exp_op);
        checks++; if (!seen || bus.intr_op !== exp_op) begin fails++; $display("FAIL to_first: got vld=%b op=%0d want vld=1 op=%0d", seen, bus.intr_op, exp_op); end
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.intr_vld && n < 20);
        checks++; if (n !== 10) begin fails++; $display("FAIL to_cycles: got vld after %0d cycles want 10", n); end
        pop_exp(exp_op);
        checks++; if (bus.intr_op !== exp_op) begin fails++; $display("FAIL to_next_op: got %0d want %0d", bus.intr_op, exp_op); end
        tick();
        do_clr();
    endtask

    initial begin
        bus.intr_rdy = 1'b0;
        bus.intr_clr = 1'b0;
        test_reset();
        test_single_ext();
        test_priority();
        test_debug();
        test_backpressure();
        test_withdrawal();
        test_set_wins();
        test_reset_mid();
        test_timeout();
        checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
